// File: rtl/fc_init_tracker.sv
// fc_init_tracker: per-VC flow-control initialisation tracker.
// Runs one FSM per VC (IDLE/FI1/FI2/DONE). It captures the InitFC1 credits of each
// posted/non-posted/completion type, schedules InitFC DLLP resend bursts and exposes
// the captured credits on a combinational read port.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   link_up, vc_en      - data-link up, per-VC enable
//   dllp_valid/data     - received DLLP strobe and payload
//   tx_req/ack/fc2/vc/ptype - InitFC transmit request handshake
//   rd_vc, rd_ptype     - credit read select
//   rd_*                - captured credits and infinite flags
//   vc_state            - 2 bits per VC FSM state
//   fc_err              - one-cycle protocol error pulse
// Compile switch: FC_SCALED_EN enables credit scaling and the scale-consistency check.
module fc_init_tracker #(
  parameter int NUM_VC       = 2,
  parameter int TIMER_PERIOD = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  link_up,
  input  logic [NUM_VC-1:0]     vc_en,
  input  logic                  dllp_valid,
  input  logic [31:0]           dllp_data,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic                  tx_fc2,
  output logic [2:0]            tx_vc,
  output logic [1:0]            tx_ptype,
  input  logic [2:0]            rd_vc,
  input  logic [1:0]            rd_ptype,
  output logic [11:0]           rd_hdr_credit,
  output logic [16:0]           rd_data_credit,
  output logic                  rd_hdr_inf,
  output logic                  rd_data_inf,
  output logic [2*NUM_VC-1:0]   vc_state,
  output logic                  fc_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, FI1 = 2'd1, FI2 = 2'd2, DONE = 2'd3} vc_st_t;

  localparam int            TW           = $clog2(TIMER_PERIOD);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMER_PERIOD - 1);
  localparam logic [3:0]    NUM_VC_W     = 4'(NUM_VC);

`ifdef FC_SCALED_EN
  function automatic logic [11:0] hdr_scale(input logic [7:0] v, input logic [1:0] s);
    case (s)
      2'b10:   hdr_scale = {2'b00, v, 2'b00};
      2'b11:   hdr_scale = {v, 4'b0000};
      default: hdr_scale = {4'b0000, v};
    endcase
  endfunction

  function automatic logic [16:0] data_scale(input logic [12:0] v, input logic [1:0] s);
    case (s)
      2'b10:   data_scale = {2'b00, v, 2'b00};
      2'b11:   data_scale = {v, 4'b0000};
      default: data_scale = {4'b0000, v};
    endcase
  endfunction
`endif

  // DLLP field decode
  logic [3:0]  d_type;
  logic [2:0]  d_vc;
  logic [1:0]  d_hs, d_ds, d_pt;
  logic [7:0]  d_hdr;
  logic [12:0] d_data;
  logic        d_init1, d_init2, d_upd, d_any, d_vc_ok;

  assign {d_type, d_vc, d_hs, d_ds, d_hdr, d_data} = dllp_data;
  assign d_pt    = d_type[1:0];
  assign d_init1 = dllp_valid && (d_pt != 2'b11) && (d_type[3:2] == 2'b01);
  assign d_init2 = dllp_valid && (d_pt != 2'b11) && (d_type[3:2] == 2'b11);
  assign d_upd   = dllp_valid && (d_pt != 2'b11) && (d_type[3:2] == 2'b10);
  assign d_any   = d_init1 || d_init2 || d_upd;
  assign d_vc_ok = ({1'b0, d_vc} < NUM_VC_W);

`ifndef FC_SCALED_EN
  logic scale_unused;
  assign scale_unused = ^{d_hs, d_ds};
`endif

  vc_st_t            state_r    [NUM_VC];
  vc_st_t            state_nx_s [NUM_VC];
  logic [2:0]        mask_r     [NUM_VC];
  logic [2:0]        hinf_r     [NUM_VC];
  logic [2:0]        dinf_r     [NUM_VC];
  logic [11:0]       hdr_cr_r   [NUM_VC][3];
  logic [16:0]       data_cr_r  [NUM_VC][3];
`ifdef FC_SCALED_EN
  logic [1:0]        hsc_r      [NUM_VC][3];
  logic [1:0]        dsc_r      [NUM_VC][3];
`endif
  logic [NUM_VC-1:0] hit_s, act_s;
  logic              err_s, enter_any_s, enter_fi1_s;
  logic              run_r, entered_r, fc_err_r;
  logic [TW-1:0]     timer_r;
  logic              any_act_s, expire_s, burst_req_s;
  logic              tx_req_r, tx_fc2_r, pend_r;
  logic [2:0]        tx_vc_r;
  logic [1:0]        tx_pt_r;
  logic              first_found_s, first_fc2_s, next_found_s, next_fc2_s;
  logic [2:0]        first_vc_s, next_vc_s;

  // Gates the FSMs for one cycle after reset release so the first move lands on the second edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_r <= 1'b0;
    else     run_r <= 1'b1;
  end

  // Per-VC next-state, DLLP hit decode, error detection and entry events.
  always_comb begin
    hit_s       = '0;
    act_s       = '0;
    err_s       = d_any && !d_vc_ok;
    enter_any_s = 1'b0;
    enter_fi1_s = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      hit_s[v]      = d_any && d_vc_ok && (d_vc == 3'(v));
      state_nx_s[v] = state_r[v];
      if (!(link_up && vc_en[v])) begin
        state_nx_s[v] = IDLE;
      end else if (!run_r) begin
        state_nx_s[v] = state_r[v];
      end else begin
        case (state_r[v])
          IDLE:    state_nx_s[v] = FI1;
          FI1:     if (mask_r[v] == 3'b111) state_nx_s[v] = FI2; else state_nx_s[v] = FI1;
          FI2:     if (hit_s[v] && (d_init2 || d_upd)) state_nx_s[v] = DONE; else state_nx_s[v] = FI2;
          DONE:    state_nx_s[v] = DONE;
          default: state_nx_s[v] = IDLE;
        endcase
      end
      if (hit_s[v] && (state_r[v] == IDLE)) err_s = 1'b1; else err_s = err_s;
`ifdef FC_SCALED_EN
      // InitFC2 must repeat the scale captured from InitFC1 (zero means "unscaled").
      for (int p = 0; p < 3; p++) begin
        if (hit_s[v] && d_init2 && (d_pt == 2'(p)) && ((state_r[v] == FI2) || (state_r[v] == DONE)) &&
            (((d_hs != 2'b00) && (d_hs != hsc_r[v][p])) || ((d_ds != 2'b00) && (d_ds != dsc_r[v][p]))))
          err_s = 1'b1;
        else
          err_s = err_s;
      end
`endif
      act_s[v] = (state_r[v] == FI1) || (state_r[v] == FI2);
      if ((state_nx_s[v] != state_r[v]) && ((state_nx_s[v] == FI1) || (state_nx_s[v] == FI2)))
        enter_any_s = 1'b1;
      else
        enter_any_s = enter_any_s;
      if ((state_r[v] == IDLE) && (state_nx_s[v] == FI1)) enter_fi1_s = 1'b1; else enter_fi1_s = enter_fi1_s;
    end
  end

  // FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int v = 0; v < NUM_VC; v++) state_r[v] <= IDLE;
    else     for (int v = 0; v < NUM_VC; v++) state_r[v] <= state_nx_s[v];
  end

  // Credit capture: first InitFC1 per ptype in FI1 wins; a disabled VC is wiped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        mask_r[v] <= 3'b000; hinf_r[v] <= 3'b000; dinf_r[v] <= 3'b000;
        for (int p = 0; p < 3; p++) begin
          hdr_cr_r[v][p] <= 12'd0; data_cr_r[v][p] <= 17'd0;
`ifdef FC_SCALED_EN
          hsc_r[v][p] <= 2'b00; dsc_r[v][p] <= 2'b00;
`endif
        end
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (!(link_up && vc_en[v])) begin
          mask_r[v] <= 3'b000; hinf_r[v] <= 3'b000; dinf_r[v] <= 3'b000;
          for (int p = 0; p < 3; p++) begin
            hdr_cr_r[v][p] <= 12'd0; data_cr_r[v][p] <= 17'd0;
`ifdef FC_SCALED_EN
            hsc_r[v][p] <= 2'b00; dsc_r[v][p] <= 2'b00;
`endif
          end
        end else if (hit_s[v] && d_init1 && (state_r[v] == FI1)) begin
          for (int p = 0; p < 3; p++) begin
            if ((d_pt == 2'(p)) && !mask_r[v][p]) begin
              mask_r[v][p] <= 1'b1;
              hinf_r[v][p] <= (d_hdr == 8'd0);
              dinf_r[v][p] <= (d_data == 13'd0);
`ifdef FC_SCALED_EN
              hdr_cr_r[v][p]  <= hdr_scale(d_hdr, d_hs);
              data_cr_r[v][p] <= data_scale(d_data, d_ds);
              hsc_r[v][p] <= d_hs; dsc_r[v][p] <= d_ds;
`else
              hdr_cr_r[v][p]  <= {4'b0000, d_hdr};
              data_cr_r[v][p] <= {4'b0000, d_data};
`endif
            end
          end
        end
      end
    end
  end

  assign any_act_s   = |act_s;
  assign expire_s    = any_act_s && (timer_r == '0);
  assign burst_req_s = entered_r || expire_s;

  // Resend timer; reloads when the first VC starts initialising and on each expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r   <= '0;
      entered_r <= 1'b0;
      fc_err_r  <= 1'b0;
    end else begin
      entered_r <= enter_any_s;
      fc_err_r  <= err_s;
      if ((!any_act_s && enter_fi1_s) || expire_s) timer_r <= TIMER_RELOAD;
      else if (any_act_s)                         timer_r <= timer_r - 1'b1;
    end
  end

  // Lowest initialising VC overall, and lowest one above the VC currently being sent.
  always_comb begin
    first_found_s = 1'b0; first_vc_s = 3'd0; first_fc2_s = 1'b0;
    next_found_s  = 1'b0; next_vc_s  = 3'd0; next_fc2_s  = 1'b0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (act_s[v]) begin
        first_found_s = 1'b1; first_vc_s = 3'(v); first_fc2_s = (state_r[v] == FI2);
        if (3'(v) > tx_vc_r) begin
          next_found_s = 1'b1; next_vc_s = 3'(v); next_fc2_s = (state_r[v] == FI2);
        end else begin
          next_found_s = next_found_s;
        end
      end else begin
        first_found_s = first_found_s;
      end
    end
  end

  // Burst sequencer: P/NP/Cpl per initialising VC in ascending order, one pending re-request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_req_r <= 1'b0; tx_fc2_r <= 1'b0; tx_vc_r <= 3'd0; tx_pt_r <= 2'd0; pend_r <= 1'b0;
    end else if (!tx_req_r) begin
      if (burst_req_s || pend_r) begin
        pend_r <= 1'b0;
        if (first_found_s) begin
          tx_req_r <= 1'b1; tx_vc_r <= first_vc_s; tx_pt_r <= 2'd0; tx_fc2_r <= first_fc2_s;
        end
      end
    end else begin
      if (burst_req_s) pend_r <= 1'b1;
      if (tx_ack) begin
        if (tx_pt_r != 2'd2) begin
          tx_pt_r <= tx_pt_r + 2'd1;
        end else if (next_found_s) begin
          tx_vc_r <= next_vc_s; tx_pt_r <= 2'd0; tx_fc2_r <= next_fc2_s;
        end else begin
          tx_req_r <= 1'b0; tx_vc_r <= 3'd0; tx_pt_r <= 2'd0; tx_fc2_r <= 1'b0;
        end
      end
    end
  end

  assign tx_req   = tx_req_r;
  assign tx_fc2   = tx_fc2_r;
  assign tx_vc    = tx_vc_r;
  assign tx_ptype = tx_pt_r;
  assign fc_err   = fc_err_r;

  // State export and combinational credit read; unmatched selects read zero.
  always_comb begin
    vc_state       = '0;
    rd_hdr_credit  = 12'd0;
    rd_data_credit = 17'd0;
    rd_hdr_inf     = 1'b0;
    rd_data_inf    = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      vc_state[2*v +: 2] = state_r[v];
      for (int p = 0; p < 3; p++) begin
        if ((rd_vc == 3'(v)) && (rd_ptype == 2'(p))) begin
          rd_hdr_credit  = hdr_cr_r[v][p];
          rd_data_credit = data_cr_r[v][p];
          rd_hdr_inf     = hinf_r[v][p];
          rd_data_inf    = dinf_r[v][p];
        end else begin
          rd_hdr_inf = rd_hdr_inf;
        end
      end
    end
  end
endmodule

// File: doc/fc_init_tracker.md
FC_INIT_TRACKER -- requirements
Module: fc_init_tracker

Interface
REQ-001 SHALL have parameter NUM_VC, default 2, number of VCs tracked (1..8).
REQ-002 SHALL have parameter TIMER_PERIOD, default 1024, clk cycles between InitFC resend bursts (>=16).
REQ-003 SHALL have ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- link_up  input  1  DL link up.
- vc_en  input  NUM_VC  per-VC enable; bit0 is VC0.
- dllp_valid  input  1  received DLLP strobe.
- dllp_data  input  32  [31:28] type, [27:25] vc, [24:23] hdr scale, [22:21] data scale, [20:13] HdrFC, [12:0] DataFC.
- tx_req  output  1  request to send an InitFC DLLP.
- tx_ack  input  1  request accepted.
- tx_fc2  output  1  0 = InitFC1, 1 = InitFC2.
- tx_vc  output  3  VC of request.
- tx_ptype  output  2  0 = P, 1 = NP, 2 = Cpl.
- rd_vc  input  3, rd_ptype  input  2  credit read select.
- rd_hdr_credit  output  12, rd_data_credit  output  17  captured credits.
- rd_hdr_inf  output  1, rd_data_inf  output  1  infinite credits.
- vc_state  output  2*NUM_VC  per-VC state.
- fc_err  output  1  one-cycle protocol-error pulse.

Function
REQ-004 SHALL decode type codes: 0100/0101/0110 = InitFC1 P/NP/Cpl; 1100/1101/1110 = InitFC2 P/NP/Cpl; 1000/1001/1010 = UpdateFC P/NP/Cpl. All other codes SHALL be ignored.
REQ-005 SHALL run one FSM per VC with states IDLE=0, FI1=1, FI2=2, DONE=3, visible on vc_state[2v+1:2v].
REQ-006 IDLE->FI1 SHALL occur when link_up & vc_en[v]. Any state->IDLE SHALL occur one cycle after link_up or vc_en[v] falls, clearing that VC's credits and received mask.
REQ-007 In FI1, the first InitFC1 per ptype SHALL latch its credits and set the mask bit; repeats SHALL be ignored. The FSM SHALL go to FI2 on the cycle after the mask reaches 3'b111.
REQ-008 In FI2, any InitFC2 or UpdateFC for the VC SHALL move it to DONE next cycle. InitFC1 in FI2 SHALL be ignored.
REQ-009 In DONE, InitFC1/InitFC2 SHALL be ignored. Credits SHALL be frozen.
REQ-010 A DLLP with vc >= NUM_VC, or addressed to a VC in IDLE, SHALL pulse fc_err on the next cycle and change no state.
REQ-011 HdrFC==0 SHALL set hdr_inf. DataFC==0 SHALL set data_inf. Both SHALL be evaluated before scaling.
REQ-012 The resend timer SHALL count while any VC is in FI1/FI2. It SHALL reload to TIMER_PERIOD-1 when the first VC enters FI1 and on each expiry.
REQ-013 On expiry, or one cycle after any VC enters FI1 or FI2, a burst SHALL be scheduled.
- A burst sends P, NP, Cpl for each VC in FI1/FI2, in ascending VC order.
- tx_fc2 = (state==FI2), latched at the start of each VC's triple.
REQ-014 tx_req/tx_vc/tx_fc2/tx_ptype SHALL stay stable while tx_req & !tx_ack and advance one step per accepted cycle. A burst request arriving mid-burst SHALL set a single pending flag, serviced after the current burst.
REQ-015 A VC leaving FI1/FI2 mid-burst SHALL finish its current triple. It SHALL then be skipped.
REQ-016 Read port SHALL be combinational. rd_vc >= NUM_VC or rd_ptype==3 SHALL return all zeros.

Reset
REQ-017 rst SHALL asynchronously force all outputs to 0.
- All FSMs SHALL go to IDLE.
- Credits, masks, timer, pending flag and burst pointer SHALL be cleared.
REQ-018 The first FSM transition after rst deasserts SHALL occur on the second clk edge.

Configuration
REQ-019 Macro FC_SCALED_EN SHALL be the only compile switch.
- Defined: captured credits are scaled. Scale 00/01 = x1, 10 = x4, 11 = x16. A nonzero scale on an InitFC2 that differs from the captured InitFC1 scale pulses fc_err.
- Undefined: scale fields are ignored, credits are stored x1, and the upper bits of rd_hdr_credit/rd_data_credit read 0.

Verification
REQ-020 The bench SHALL cover:
- NUM_VC=2, vc_en=01, link_up=1, InitFC1 P/NP/Cpl on VC0 with HdrFC=0x20, DataFC=0x100 -> vc_state[1:0] 1->2; rd returns 0x020/0x00100, inf=0.
- VC0 in FI2, UpdateFC-NP on VC0 -> vc_state[1:0]=3 next cycle.
- InitFC1-P with HdrFC=0, DataFC=0 -> rd_hdr_inf=1, rd_data_inf=1.
- dllp vc=5 -> fc_err one-cycle pulse; no state change.
- TIMER_PERIOD=16, tx_ack held 0 for 3 cycles -> tx fields stable; then 3 acks yield ptype 0,1,2; next burst 16 cycles after the reload.
- FC_SCALED_EN defined, HdrFC=0x10, hdr scale=10 -> rd_hdr_credit=0x040. rst asserted mid-burst -> tx_req=0 immediately.
